// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph patterns, digit count, line
// polarities and the anode-to-digit select helper.
package seg7_pkg;

  // Number of multiplexed digits on the display.
  localparam int DIGITS = 4;

  // Asserted level of each display line group as it appears on the pins.
  localparam logic SEG_ON = 1'b0;
  localparam logic DP_ON  = 1'b0;
  localparam logic AN_ON  = 1'b0;

  // Active-high glyph patterns, bit order g..a (bit0 = segment a).
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Result of looking at the anode lines: hit is set only when exactly one
  // digit is driven, idx names that digit.
  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } digit_sel_t;

  // Blank (no anode) and ghosting (several anodes) samples give hit = 0.
  function automatic digit_sel_t activeDigit(input logic [DIGITS-1:0] anPins);
    logic [DIGITS-1:0] anAct;
    digit_sel_t        sel;
    anAct   = (AN_ON == 1'b0) ? ~anPins : anPins;
    sel.hit = $onehot(anAct);
    sel.idx = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (anAct[i]) begin
        sel.idx = 2'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-side lines coming into the scan decoder plus the recovered
// value/status lines going out of it.
interface seg_scan_decoder_if;
  import seg7_pkg::*;

  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] an_n;

  logic [15:0]       value_out;
  logic [DIGITS-1:0] dp_out;
  logic              value_valid;
  logic              value_changed;
  logic              digit_err;
  logic              scan_lost;

  // The side driving the display pins and watching the results.
  modport master (
    output seg_n, dp_n, an_n,
    input  value_out, dp_out, value_valid, value_changed, digit_err, scan_lost
  );

  // The decoder itself.
  modport slave (
    input  seg_n, dp_n, an_n,
    output value_out, dp_out, value_valid, value_changed, digit_err, scan_lost
  );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Turns an active-high seven-segment pattern back into its hex nibble.
// Patterns outside the sixteen known glyphs report valid_o = 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] glyph_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  // Exact-match lookup; a partially lit or corrupted glyph is never guessed.
  always_comb begin
    valid_o  = 1'b1;
    nibble_o = 4'h0;
    case (glyph_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 4-digit seven-segment display. Each digit dwell
// must be stable for STABLE_CYCLES samples before it is taken; four distinct
// digits make a frame, and a clean frame updates value_out/dp_out.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
)
(
  input logic          fpga_clk1,
  input logic          rst,
  seg_scan_decoder_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 2);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);

  // Registered copy of the pins; everything downstream works on these.
  logic [6:0]        segN_q;
  logic              dpN_q;
  logic [DIGITS-1:0] anN_q;
  logic [11:0]       samplePrev_q;

  logic [SW-1:0]     stabCnt_q, stabCnt_d;
  logic [IW-1:0]     idleCnt_q, idleCnt_d;

  logic [DIGITS-1:0]       seen_q, seen_d;
  logic                    frameBad_q, frameBad_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0]       dpShadow_q, dpShadow_d;

  logic [15:0]       valueOut_q, valueOut_d;
  logic [DIGITS-1:0] dpOut_q, dpOut_d;
  logic              valueValid_q, valueValid_d;
  logic              valueChanged_q, valueChanged_d;
  logic              digitErr_q, digitErr_d;
  logic              scanLost_q, scanLost_d;

  logic [11:0]  sample;
  digit_sel_t   sel;
  logic         sameSample;
  logic         accept;
  logic [6:0]   segActive;
  logic         dpActive;
  logic         glyphValid;
  logic [3:0]   glyphNibble;
  logic         frameDone;
  logic         timedOut;

  assign sample     = {anN_q, segN_q, dpN_q};
  assign sel        = activeDigit(anN_q);
  assign sameSample = (sample == samplePrev_q);
  assign segActive  = (SEG_ON == 1'b0) ? ~segN_q : segN_q;
  assign dpActive   = (DP_ON == 1'b0) ? ~dpN_q : dpN_q;
  assign frameDone  = (seen_q == {DIGITS{1'b1}});

  seg7_glyph_decode u_glyph (
    .glyph_i  (segActive),
    .valid_o  (glyphValid),
    .nibble_o (glyphNibble)
  );

  // One pipeline stage on the pins, plus the previous sample for the
  // stability compare. Pins reset to the idle (all-off) level.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      segN_q       <= {7{~SEG_ON}};
      dpN_q        <= ~DP_ON;
      anN_q        <= {DIGITS{~AN_ON}};
      samplePrev_q <= {{DIGITS{~AN_ON}}, {7{~SEG_ON}}, ~DP_ON};
    end else begin
      segN_q       <= bus.seg_n;
      dpN_q        <= bus.dp_n;
      anN_q        <= bus.an_n;
      samplePrev_q <= sample;
    end
  end

  // Dwell counter: accept fires once on the step to STAB_MAX, then the
  // counter parks there so a long dwell is never taken twice.
  always_comb begin
    stabCnt_d = '0;
    accept    = 1'b0;
    if (sel.hit && sameSample) begin
      if (stabCnt_q == STAB_MAX) begin
        stabCnt_d = STAB_MAX;
      end else begin
        stabCnt_d = stabCnt_q + 1'b1;
        accept    = (stabCnt_q == STAB_LAST);
      end
    end
  end

  // Idle timer since the last accepted digit; scan_lost mirrors saturation,
  // so it drops one cycle after the next acceptance.
  always_comb begin
    idleCnt_d = idleCnt_q;
    if (accept) begin
      idleCnt_d = '0;
    end else if (idleCnt_q != IDLE_MAX) begin
      idleCnt_d = idleCnt_q + 1'b1;
    end
    timedOut   = (idleCnt_d == IDLE_MAX);
    scanLost_d = timedOut;
  end

  // Frame assembly: completion and timeout empty the frame first, then a
  // newly accepted digit is merged on top. A digit that disagrees with what
  // was already seen for its position means the source changed mid-scan, so
  // the frame restarts from that digit. Undecodable digits always restart or
  // poison the frame.
  always_comb begin
    seen_d         = seen_q;
    frameBad_d     = frameBad_q;
    shadow_d       = shadow_q;
    dpShadow_d     = dpShadow_q;
    valueOut_d     = valueOut_q;
    dpOut_d        = dpOut_q;
    valueValid_d   = 1'b0;
    valueChanged_d = 1'b0;
    digitErr_d     = 1'b0;

    if (frameDone) begin
      if (!frameBad_q) begin
        valueOut_d     = shadow_q;
        dpOut_d        = dpShadow_q;
        valueValid_d   = 1'b1;
        valueChanged_d = (shadow_q != valueOut_q);
      end
      seen_d     = '0;
      frameBad_d = 1'b0;
    end

    if (timedOut) begin
      seen_d     = '0;
      frameBad_d = 1'b0;
    end

    if (accept) begin
      digitErr_d = ~glyphValid;
      if (!seen_d[sel.idx]) begin
        shadow_d[sel.idx]   = glyphNibble;
        dpShadow_d[sel.idx] = dpActive;
        seen_d[sel.idx]     = 1'b1;
        if (!glyphValid) begin
          frameBad_d = 1'b1;
        end
      end else if (!glyphValid || (glyphNibble != shadow_d[sel.idx]) ||
                   (dpActive != dpShadow_d[sel.idx])) begin
        seen_d              = '0;
        seen_d[sel.idx]     = 1'b1;
        shadow_d[sel.idx]   = glyphNibble;
        dpShadow_d[sel.idx] = dpActive;
        frameBad_d          = ~glyphValid;
      end
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      stabCnt_q      <= '0;
      idleCnt_q      <= '0;
      seen_q         <= '0;
      frameBad_q     <= 1'b0;
      shadow_q       <= '0;
      dpShadow_q     <= '0;
      valueOut_q     <= '0;
      dpOut_q        <= '0;
      valueValid_q   <= 1'b0;
      valueChanged_q <= 1'b0;
      digitErr_q     <= 1'b0;
      scanLost_q     <= 1'b0;
    end else begin
      stabCnt_q      <= stabCnt_d;
      idleCnt_q      <= idleCnt_d;
      seen_q         <= seen_d;
      frameBad_q     <= frameBad_d;
      shadow_q       <= shadow_d;
      dpShadow_q     <= dpShadow_d;
      valueOut_q     <= valueOut_d;
      dpOut_q        <= dpOut_d;
      valueValid_q   <= valueValid_d;
      valueChanged_q <= valueChanged_d;
      digitErr_q     <= digitErr_d;
      scanLost_q     <= scanLost_d;
    end
  end

  assign bus.value_out     = valueOut_q;
  assign bus.dp_out        = dpOut_q;
  assign bus.value_valid   = valueValid_q;
  assign bus.value_changed = valueChanged_q;
  assign bus.digit_err     = digitErr_q;
  assign bus.scan_lost     = scanLost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table of full scans plus hand-written
// glitch, restart, ghosting, timeout and reset sequences.
module tb_seg_scan_decoder;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F;
  localparam logic [6:0] G4 = 7'h66, G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07;
  localparam logic [6:0] G8 = 7'h7F, G9 = 7'h6F, GA = 7'h77, GB = 7'h7C;
  localparam logic [6:0] GC = 7'h39, GD = 7'h5E, GE = 7'h79, GF = 7'h71;
  localparam logic [6:0] GBAD = 7'h01;

  typedef struct {
    string           name;
    logic [3:0][6:0] glyphs;
    logic [3:0]      dpMask;
    logic [15:0]     expValue;
    logic [3:0]      expDp;
    int              expValid;
    int              expChanged;
    int              expErr;
  } vec_t;

  logic clock;
  logic reset;
  int   testsRun;
  int   failures;
  int   validSeen;
  int   changedSeen;
  int   errSeen;
  vec_t vecs [7];

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .fpga_clk1 (clock),
    .rst       (reset),
    .bus       (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count one-cycle pulses, sampled mid-cycle.
  initial begin
    validSeen   = 0;
    changedSeen = 0;
    errSeen     = 0;
  end

  always @(negedge clock) begin
    if (bus.value_valid === 1'b1) validSeen <= validSeen + 1;
    if (bus.value_changed === 1'b1) changedSeen <= changedSeen + 1;
    if (bus.digit_err === 1'b1) errSeen <= errSeen + 1;
  end

  // Hard stop in case the run wanders off.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic holdCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic blank(input int n);
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    holdCycles(n);
  endtask

  task automatic applyStimulus(input int digit, input logic [6:0] glyph,
                               input logic dp, input int cycles);
    bus.an_n  = ~(4'b0001 << digit);
    bus.seg_n = ~glyph;
    bus.dp_n  = ~dp;
    holdCycles(cycles);
  endtask

  task automatic scanFrame(input logic [3:0][6:0] glyphs, input logic [3:0] dpMask);
    for (int d = 0; d < 4; d++) begin
      applyStimulus(d, glyphs[d], dpMask[d], 20);
      blank(2);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int v0, c0, e0;
    testsRun = 0;
    failures = 0;

    vecs[0] = '{"clean 1A3F",   {G1, GA, G3, GF}, 4'b0000, 16'h1A3F, 4'b0000, 1, 1, 0};
    vecs[1] = '{"repeat 1A3F",  {G1, GA, G3, GF}, 4'b0000, 16'h1A3F, 4'b0000, 1, 0, 0};
    vecs[2] = '{"dp only",      {G1, GA, G3, GF}, 4'b0101, 16'h1A3F, 4'b0101, 1, 0, 0};
    vecs[3] = '{"CB98",         {GC, GB, G9, G8}, 4'b0000, 16'hCB98, 4'b0000, 1, 1, 0};
    vecs[4] = '{"2ED0 dp",      {G2, GE, GD, G0}, 4'b1000, 16'h2ED0, 4'b1000, 1, 1, 0};
    vecs[5] = '{"7654",         {G7, G6, G5, G4}, 4'b0000, 16'h7654, 4'b0000, 1, 1, 0};
    vecs[6] = '{"bad an2",      {G7, GBAD, G5, G4}, 4'b0000, 16'h7654, 4'b0000, 0, 0, 1};

    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    reset     = 1'b1;
    holdCycles(3);
    reset = 1'b0;
    holdCycles(1);

    $display("[TB] reset state");
    checkOutput("reset value_out", bus.value_out, 0);
    checkOutput("reset dp_out", bus.dp_out, 0);
    checkOutput("reset value_valid", bus.value_valid, 0);
    checkOutput("reset value_changed", bus.value_changed, 0);
    checkOutput("reset digit_err", bus.digit_err, 0);
    checkOutput("reset scan_lost", bus.scan_lost, 0);

    $display("[TB] table of full scans");
    for (int i = 0; i < 7; i++) begin
      v0 = validSeen; c0 = changedSeen; e0 = errSeen;
      scanFrame(vecs[i].glyphs, vecs[i].dpMask);
      blank(3);
      checkOutput({vecs[i].name, " value"}, bus.value_out, vecs[i].expValue);
      checkOutput({vecs[i].name, " dp"}, bus.dp_out, vecs[i].expDp);
      checkOutput({vecs[i].name, " valid pulses"}, validSeen - v0, vecs[i].expValid);
      checkOutput({vecs[i].name, " changed pulses"}, changedSeen - c0, vecs[i].expChanged);
      checkOutput({vecs[i].name, " err pulses"}, errSeen - e0, vecs[i].expErr);
    end

    $display("[TB] glitch rejection");
    v0 = validSeen; c0 = changedSeen; e0 = errSeen;
    applyStimulus(0, G5, 1'b0, 10);
    applyStimulus(0, G6, 1'b0, 20);
    blank(2);
    for (int d = 1; d < 4; d++) begin
      applyStimulus(d, G0, 1'b0, 20);
      blank(2);
    end
    blank(3);
    checkOutput("glitch value", bus.value_out, 16'h0006);
    checkOutput("glitch valid pulses", validSeen - v0, 1);
    checkOutput("glitch changed pulses", changedSeen - c0, 1);

    $display("[TB] mid-scan restart");
    v0 = validSeen;
    applyStimulus(0, G3, 1'b0, 20); blank(2);
    applyStimulus(1, G4, 1'b0, 20); blank(2);
    applyStimulus(0, G7, 1'b0, 20); blank(2);
    applyStimulus(1, G4, 1'b0, 20); blank(2);
    applyStimulus(2, G2, 1'b0, 20); blank(2);
    applyStimulus(3, G9, 1'b0, 20); blank(5);
    checkOutput("restart value", bus.value_out, 16'h9247);
    checkOutput("restart valid pulses", validSeen - v0, 1);

    $display("[TB] two anodes low");
    v0 = validSeen; e0 = errSeen;
    bus.an_n  = 4'b1100;
    bus.seg_n = ~G8;
    bus.dp_n  = 1'b1;
    holdCycles(100);
    checkOutput("ghost valid pulses", validSeen - v0, 0);
    checkOutput("ghost err pulses", errSeen - e0, 0);
    checkOutput("ghost value", bus.value_out, 16'h9247);
    checkOutput("ghost scan_lost", bus.scan_lost, 1);
    applyStimulus(0, G1, 1'b0, 20);
    checkOutput("recover scan_lost", bus.scan_lost, 0);

    $display("[TB] timeout");
    blank(30);
    checkOutput("early scan_lost", bus.scan_lost, 0);
    blank(40);
    checkOutput("timeout scan_lost", bus.scan_lost, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, G1, 1'b0, 20); blank(2);
    applyStimulus(1, G2, 1'b1, 20);
    reset = 1'b1;
    holdCycles(2);
    reset = 1'b0;
    blank(1);
    v0 = validSeen;
    checkOutput("midreset value", bus.value_out, 0);
    checkOutput("midreset dp", bus.dp_out, 0);
    checkOutput("midreset scan_lost", bus.scan_lost, 0);
    checkOutput("midreset value_valid", bus.value_valid, 0);
    applyStimulus(2, G5, 1'b0, 20); blank(2);
    applyStimulus(3, G6, 1'b0, 20); blank(5);
    checkOutput("partial discarded valid", validSeen - v0, 0);
    checkOutput("partial discarded value", bus.value_out, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit seven-segment interface driven by SensorController.
- Samples the anode/segment/dp lines, decodes each hex glyph and reassembles the displayed 16-bit value.
- Used for on-board loopback self-test of the display path and to recover the counter value from another board's display pins.
- Sits beside SensorController in the top level and shares fpga_clk1 with it.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is accepted (≥2).
- TIMEOUT_CYCLES, 1048576: cycles without any accepted digit before scan_lost asserts.

Ports:
- fpga_clk1  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- seg_n  input  7  segments, active-low; bit0=a … bit6=g (seg0..seg6).
- dp_n  input  1  decimal point, active-low.
- an_n  input  4  digit anodes, active-low; an_n[0] = rightmost digit = value[3:0].
- value_out  output  16  last fully received value.
- dp_out  output  4  dp state per digit of last frame, active-high.
- value_valid  output  1  one-cycle pulse when value_out/dp_out update.
- value_changed  output  1  one-cycle pulse with value_valid when the new value differs from the previous value_out.
- digit_err  output  1  one-cycle pulse on an accepted, stable but undecodable glyph.
- scan_lost  output  1  level; no digit accepted for TIMEOUT_CYCLES.

Behaviour:
- Reset: all outputs 0. Internal state cleared: seen mask, shadow, counters, frame_bad.
- Input stage: seg_n, dp_n and an_n are registered once, adding 1 cycle of latency. All following logic uses the registered copy.
- Select: a sample is a digit sample only when exactly one an_n bit is 0.
  - All-high (blank) or more than one low: the stability counter is cleared and no digit is accepted.
- Stability: stab_cnt increments while {an_n, seg_n, dp_n} matches the previous sample and clears on any change.
  - When stab_cnt reaches STABLE_CYCLES-1, the digit is accepted exactly once.
  - The counter then saturates, so a single dwell is never accepted twice.
- Decode (active-high g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern: digit_err pulses, frame_bad is set, and the seen bit for that digit is set.
- Frame assembly on acceptance of digit k:
  - seen[k]=0: store nibble in shadow[k], store dp in dp_shadow[k], set seen[k].
  - seen[k]=1 and nibble or dp differs: restart the frame. seen becomes only bit k, shadow[k] is updated and frame_bad is cleared (unless this digit is itself bad).
  - seen[k]=1 and identical: no action.
- Completion: in the cycle after seen becomes 4'b1111:
  - frame_bad=0: value_out<=shadow, dp_out<=dp_shadow, value_valid=1; value_changed=1 if the value differs.
  - frame_bad=1: no update and no pulse.
  - In both cases seen and frame_bad are cleared.
- Timeout: idle_cnt clears on every acceptance and otherwise counts, saturating.
  - At TIMEOUT_CYCLES: scan_lost=1, and seen and frame_bad clear.
  - scan_lost drops in the cycle after the next acceptance.
- Reset mid-frame discards the partial frame. value_out returns to 0 with no value_valid.
- Widths: stab_cnt is $clog2(STABLE_CYCLES) bits; idle_cnt is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package seg7_pkg:
  - 7-bit glyph constants for 0–F (also used by SensorController's encoder).
  - Digit count 4.
  - Polarity constants.
- One sub-module, seg7_glyph_decode: combinational 7-bit glyph to {valid, nibble[3:0]}.
- Stability counter, frame assembly and timeout remain in the top module.

Test Plan:
- Clean scan of 16'h1A3F: each digit is held 20 cycles, order an0→an3, with 2 blank cycles between digits. Expect value_valid once per 4 digits, value_out=16'h1A3F, and value_changed on the first frame only.
- Glitch rejection: digit an0 shows "5" for 10 cycles and then "6" for 20 cycles (STABLE_CYCLES=16). Expect only "6" to be accepted; with the other digits 0, value_out=16'h0006.
- Invalid glyph: an2 carries 7'h01 (segment a only) held 20 cycles. Expect one digit_err pulse; that frame gives no value_valid and value_out keeps its prior value.
- Mid-scan change: an0="3", an1="4", then an0 is re-shown as "7", then an1..an3 are shown. Expect the frame to restart and value_out={an3,an2,an1,7}.
- Two anodes low: an_n=4'b1100 for 100 cycles. Expect no acceptance, no pulses, and the state unchanged.
- Timeout and reset: with TIMEOUT_CYCLES=64, hold blank for 64 cycles. Expect scan_lost=1; a following valid digit clears it. Asserting rst during a half-done frame clears all outputs to 0.
